object_line_renderer: RTL and testbench

- Sits directly downstream of the game controller. Captures the controller's 8-entry object RAM write stream, which is the sole source of object positions.
- During each horizontal blank, builds a per-row occupancy buffer of 19 tile columns. During active video, turns pixel coordinates into tile-ROM addresses and returns object pixel colour plus a hit flag.
- Its output feeds the pixel mixer, which overlays object pixels on the background.

---
 rtl/object_line_renderer_pkg.sv | 30 +++
 rtl/object_line_renderer_if.sv | 9 +
 rtl/object_line_renderer_buffer.sv | 37 +++
 rtl/object_line_renderer.sv | 147 ++++++++++++++
 tb/tb_object_line_renderer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/object_line_renderer_pkg.sv
// Shared constants, object word layout and FSM encoding
// for the object line renderer.
package object_line_renderer_pkg;

  localparam int TILE_SHIFT = 5;
  localparam int N_OBJ = 8;
  localparam logic [4:0] GRID_W = 5'd19;
  localparam logic [4:0] GRID_H = 5'd15;
  localparam logic [7:0] TRANSP = 8'h00;

  localparam int OBJ_ON = 12;
  localparam int OBJ_TILE_HI = 11;
  localparam int OBJ_TILE_LO = 9;
  localparam int OBJ_X_HI = 8;
  localparam int OBJ_X_LO = 4;
  localparam int OBJ_Y_HI = 3;
  localparam int OBJ_Y_LO = 0;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCAN
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] tile;
  } slot_t;

endpackage

// File: rtl/object_line_renderer_if.sv
// Object RAM write bus from the game controller.
interface object_line_renderer_if;
  logic [2:0]  addr;
  logic [12:0] data;
  logic        we;

  modport master(output addr, data, we);
  modport slave(input addr, data, we);
endinterface

// File: rtl/object_line_renderer_buffer.sv
// 19-slot per-row occupancy buffer with clear/write
// port, pixel read port and placement probe port.
module obj_line_buffer
  import object_line_renderer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [4:0] clrIdx,
  input  logic       wr,
  input  logic [4:0] wrIdx,
  input  logic [2:0] wrTile,
  input  logic [4:0] rdIdx,
  output slot_t      rdSlot,
  input  logic [4:0] prIdx,
  output logic       prValid
);

  slot_t slots [GRID_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      slots <= '{default: '0};
    end else begin
      if (clr && clrIdx < GRID_W)
        slots[clrIdx] <= '0;
      if (wr && wrIdx < GRID_W)
        slots[wrIdx] <= {1'b1, wrTile};
    end
  end

  assign rdSlot = (rdIdx < GRID_W) ?
                  slots[rdIdx] : '0;
  assign prValid = (prIdx < GRID_W) ?
                   slots[prIdx].valid : 1'b0;

endmodule

// File: rtl/object_line_renderer.sv
// Object RAM capture, hblank line build FSM and
// two-stage object pixel pipeline.
module object_line_renderer
  import object_line_renderer_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  object_line_renderer_if.slave        objRam,
  input  logic                         iLineReq,
  input  logic [9:0]                   iLineY,
  input  logic [9:0]                   iPixX,
  input  logic                         iDE,
  output logic [12:0]                  oRom_addr,
  input  logic [7:0]                   iRom_data,
  output logic [7:0]                   oPix,
  output logic                         oObj_hit,
  output logic                         oBusy,
  output logic                         oOverrun
);

  logic [12:0] objMem [N_OBJ];
  state_t      state, nextState;
  logic [4:0]  cnt, rowIdx, lineRow;
  logic        bufClr, bufWr, place;
  logic        lastClr, lastScan;
  logic [12:0] obj;
  logic [4:0]  objX, col;
  logic        prValid;
  slot_t       rdSlot;
  logic        hit1Next, hit1, hit1d, dePrev;

  always_ff @(posedge clk) begin
    if (reset)
      objMem <= '{default: '0};
    else if (objRam.we)
      objMem[objRam.addr] <= objRam.data;
  end

  assign obj  = objMem[cnt[2:0]];
  assign objX = obj[OBJ_X_HI:OBJ_X_LO];
  assign lastClr  = (cnt == GRID_W - 5'd1);
  assign lastScan = (cnt == 5'(N_OBJ - 1));

  // rows past the grid never match, even Y=15
  assign place = obj[OBJ_ON]
              && ({1'b0, obj[OBJ_Y_HI:OBJ_Y_LO]}
                  == rowIdx)
              && (rowIdx < GRID_H)
              && (objX < GRID_W)
              && !prValid;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (iLineReq) begin
      nextState = CLEAR;
    end else begin
      unique case (state)
        IDLE:  nextState = IDLE;
        CLEAR: if (lastClr) nextState = SCAN;
        SCAN:  if (lastScan) nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    oBusy  = 1'b0;
    bufClr = 1'b0;
    bufWr  = 1'b0;
    unique case (1'b1)
      (state == CLEAR): begin
        oBusy  = 1'b1;
        bufClr = 1'b1;
      end
      (state == SCAN): begin
        oBusy = 1'b1;
        bufWr = place && !iLineReq;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      rowIdx  <= '0;
      lineRow <= '0;
    end else if (iLineReq) begin
      cnt     <= '0;
      rowIdx  <= iLineY[9:TILE_SHIFT];
      lineRow <= iLineY[TILE_SHIFT-1:0];
    end else if (state == CLEAR) begin
      cnt <= lastClr ? 5'd0 : cnt + 5'd1;
    end else if (state == SCAN) begin
      cnt <= cnt + 5'd1;
    end
  end

  obj_line_buffer u_buf (
    .clk    (clk),
    .reset  (reset),
    .clr    (bufClr),
    .clrIdx (cnt),
    .wr     (bufWr),
    .wrIdx  (objX),
    .wrTile (obj[OBJ_TILE_HI:OBJ_TILE_LO]),
    .rdIdx  (col),
    .rdSlot (rdSlot),
    .prIdx  (objX),
    .prValid(prValid)
  );

  assign col = iPixX[9:TILE_SHIFT];
  assign hit1Next = iDE && (col < GRID_W)
                 && rdSlot.valid && !oBusy;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit1      <= 1'b0;
      hit1d     <= 1'b0;
      oRom_addr <= '0;
      dePrev    <= 1'b0;
      oOverrun  <= 1'b0;
    end else begin
      hit1   <= hit1Next;
      hit1d  <= hit1;
      dePrev <= iDE;
      if (hit1Next)
        oRom_addr <= {rdSlot.tile, lineRow,
                      iPixX[TILE_SHIFT-1:0]};
      if (iDE && !dePrev && oBusy)
        oOverrun <= 1'b1;
    end
  end

  // ROM data lands with hit1d, one cycle after the address
  assign oObj_hit = hit1d && (iRom_data != TRANSP);
  assign oPix = oObj_hit ? iRom_data : 8'h00;

endmodule

// File: tb/tb_object_line_renderer.sv
// Directed + random bench for object_line_renderer
// with a column-oriented line model and tile ROM model.
module tb_object_line_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        iLineReq;
  logic [9:0]  iLineY;
  logic [9:0]  iPixX;
  logic        iDE;
  logic [12:0] oRom_addr;
  logic [7:0]  romData = 8'h00;
  logic [7:0]  oPix;
  logic        oObj_hit;
  logic        oBusy;
  logic        oOverrun;

  object_line_renderer_if objBus();

  object_line_renderer dut (
    .clk      (clk),
    .reset    (reset),
    .objRam   (objBus),
    .iLineReq (iLineReq),
    .iLineY   (iLineY),
    .iPixX    (iPixX),
    .iDE      (iDE),
    .oRom_addr(oRom_addr),
    .iRom_data(romData),
    .oPix     (oPix),
    .oObj_hit (oObj_hit),
    .oBusy    (oBusy),
    .oOverrun (oOverrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int romMode = 0;

  logic [12:0] mObj [8];
  bit          mValid [19];
  logic [2:0]  mTile [19];
  logic [4:0]  mRow;

  function automatic logic [7:0] rom(
    input logic [12:0] a);
    case (romMode)
      0: return 8'h55;
      1: return a[0] ? 8'h00 : 8'h55;
      default: return a[7:0] ^ {3'b0, a[12:8]};
    endcase
  endfunction

  always @(posedge clk) romData <= rom(oRom_addr);

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Per column: the lowest-numbered enabled object
  // sitting on this tile row owns the column.
  function automatic void buildModel(
    input logic [9:0] y);
    int r;
    r = int'(y) / 32;
    mRow = y[4:0];
    for (int c = 0; c < 19; c++) begin
      mValid[c] = 0;
      mTile[c] = 3'd0;
      if (r < 15) begin
        for (int k = 0; k < 8; k++) begin
          if (!mValid[c] && mObj[k][12]
              && int'(mObj[k][8:4]) == c
              && int'(mObj[k][3:0]) == r) begin
            mValid[c] = 1;
            mTile[c] = mObj[k][11:9];
          end
        end
      end
    end
  endfunction

  task automatic writeObj(input int k,
                          input logic [12:0] d);
    @(negedge clk);
    objBus.addr = 3'(k);
    objBus.data = d;
    objBus.we = 1'b1;
    @(negedge clk);
    objBus.we = 1'b0;
    mObj[k] = d;
  endtask

  task automatic startLine(input logic [9:0] y);
    @(negedge clk);
    iLineReq = 1'b1;
    iLineY = y;
    @(negedge clk);
    iLineReq = 1'b0;
  endtask

  task automatic waitIdle(input int start,
                          output int n);
    n = start;
    while (oBusy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic expectAt(input int x,
                          output logic hit,
                          output logic [12:0] a);
    int c;
    logic [9:0] xv;
    c = x / 32;
    xv = 10'(x);
    hit = (c < 19) ? mValid[c] : 1'b0;
    a = {(c < 19) ? mTile[c] : 3'd0, mRow, xv[4:0]};
  endtask

  task automatic sweep(input string tag);
    logic h;
    logic [12:0] a;
    logic [7:0] d;
    for (int x = 0; x < 642; x++) begin
      @(negedge clk);
      if (x >= 2) begin
        expectAt(x - 2, h, a);
        d = rom(a);
        h = h && (d != 8'h00);
        check({tag, "_hit"}, 32'(oObj_hit),
              32'(h));
        check({tag, "_pix"}, 32'(oPix),
              32'(h ? d : 8'h00));
      end
      if (x >= 1) begin
        expectAt(x - 1, h, a);
        if (h)
          check({tag, "_addr"}, 32'(oRom_addr),
                32'(a));
      end
      if (x < 640) begin
        iPixX = 10'(x);
        iDE = 1'b1;
      end else begin
        iPixX = '0;
        iDE = 1'b0;
      end
    end
  endtask

  task automatic line(input string tag,
                      input logic [9:0] y);
    int n;
    buildModel(y);
    startLine(y);
    waitIdle(0, n);
    check({tag, "_busy"}, 32'(n), 32'd27);
    sweep(tag);
  endtask

  initial begin
    int n;
    logic [9:0] ry;
    logic [12:0] rd;

    reset = 1'b1;
    iLineReq = 1'b0;
    iLineY = '0;
    iPixX = '0;
    iDE = 1'b0;
    objBus.addr = '0;
    objBus.data = '0;
    objBus.we = 1'b0;
    for (int k = 0; k < 8; k++) mObj[k] = '0;
    buildModel(10'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_addr", 32'(oRom_addr), 32'd0);
    check("rst_pix", 32'(oPix), 32'd0);
    check("rst_hit", 32'(oObj_hit), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_ovr", 32'(oOverrun), 32'd0);
    sweep("rst_line");

    romMode = 0;
    writeObj(0, {1'b1, 3'd0, 5'd1, 4'd1});
    line("single", 10'd40);
    expectAt(40, ry[0], rd);
    check("single_model", 32'(rd),
          32'({3'd0, 5'd8, 5'd8}));

    writeObj(0, {1'b1, 3'd0, 5'd5, 4'd3});
    writeObj(1, {1'b1, 3'd1, 5'd5, 4'd3});
    line("overlap", 10'd100);

    writeObj(0, {1'b0, 3'd2, 5'd1, 4'd1});
    writeObj(1, {1'b1, 3'd3, 5'd19, 4'd1});
    writeObj(2, {1'b1, 3'd4, 5'd3, 4'd2});
    line("nohit", 10'd40);

    romMode = 1;
    writeObj(3, {1'b1, 3'd6, 5'd2, 4'd1});
    line("transp", 10'd40);

    romMode = 2;
    writeObj(1, '0);
    writeObj(3, '0);
    writeObj(2, {1'b1, 3'd5, 5'd4, 4'd1});
    buildModel(10'd40);
    startLine(10'd40);
    repeat (21) @(negedge clk);
    objBus.addr = 3'd2;
    objBus.data = {1'b1, 3'd6, 5'd7, 4'd1};
    objBus.we = 1'b1;
    @(negedge clk);
    objBus.we = 1'b0;
    mObj[2] = {1'b1, 3'd6, 5'd7, 4'd1};
    waitIdle(22, n);
    check("midwr_busy", 32'(n), 32'd27);
    sweep("midwr_old");
    line("midwr_new", 10'd40);

    writeObj(0, {1'b1, 3'd3, 5'd2, 4'd1});
    writeObj(1, {1'b1, 3'd4, 5'd9, 4'd7});
    startLine(10'd40);
    repeat (5) @(negedge clk);
    buildModel(10'd227);
    startLine(10'd227);
    waitIdle(0, n);
    check("restart_busy", 32'(n), 32'd27);
    sweep("restart");

    writeObj(4, {1'b1, 3'd2, 5'd3, 4'd15});
    line("row15", 10'd490);

    for (int i = 0; i < 4; i++) begin
      ry = (i == 3) ? 10'($urandom_range(480, 1023))
                    : 10'($urandom_range(0, 479));
      for (int k = 0; k < 8; k++) begin
        rd = 13'($urandom);
        rd[12] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1)
          rd[3:0] = ry[8:5];
        writeObj(k, rd);
      end
      line("rand", ry);
    end

    romMode = 0;
    for (int k = 0; k < 8; k++) writeObj(k, '0);
    writeObj(5, {1'b1, 3'd7, 5'd18, 4'd1});
    line("edgecol", 10'd40);
    check("ovr_clear", 32'(oOverrun), 32'd0);

    startLine(10'd40);
    repeat (10) @(negedge clk);
    iDE = 1'b1;
    iPixX = 10'd590;
    @(negedge clk);
    check("ovr_set", 32'(oOverrun), 32'd1);
    @(negedge clk);
    check("ovr_hit0", 32'(oObj_hit), 32'd0);
    @(negedge clk);
    check("ovr_hit1", 32'(oObj_hit), 32'd0);
    @(negedge clk);
    check("ovr_sticky", 32'(oOverrun), 32'd1);
    check("ovr_busy", 32'(oBusy), 32'd1);
    iDE = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_busy", 32'(oBusy), 32'd0);
    check("mrst_ovr", 32'(oOverrun), 32'd0);
    check("mrst_hit", 32'(oObj_hit), 32'd0);
    check("mrst_pix", 32'(oPix), 32'd0);
    check("mrst_addr", 32'(oRom_addr), 32'd0);
    for (int k = 0; k < 8; k++) mObj[k] = '0;
    buildModel(10'd0);
    sweep("mrst_line");
    line("mrst_obj", 10'd40);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
